cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares one physical-memory (or L2) line port between the instruction cache and the data cache of the LC-3b pipeline. Each cache issues whole-line (128-bit) reads and writebacks. The arbiter grants one requester at a time with round-robin tie-break, latches that requester's address and write data, and sequences the memory handshake. It returns the response to the granted cache with a registered read line; the caches' 16-bit word-select muxes consume that line downstream.

## Interface
Parameters:
- ADDR_WIDTH, 16, line address width (lc3b_word)
- LINE_WIDTH, 128, cache line width (8 x 16-bit words)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read  in  1  icache line read request, held until i_resp
- i_addr  in  ADDR_WIDTH  icache line address
- i_resp  out  1  icache transaction complete, one-cycle pulse
- i_rdata  out  LINE_WIDTH  line returned to icache, valid while i_resp
- d_read, d_write  in  1  dcache line read / writeback, held until d_resp
- d_addr  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache writeback line
- d_resp  out  1  dcache transaction complete, one-cycle pulse
- d_rdata  out  LINE_WIDTH  line returned to dcache, valid while d_resp
- mem_read, mem_write  out  1  memory request, held until mem_resp
- mem_addr  out  ADDR_WIDTH  memory line address
- mem_wdata  out  LINE_WIDTH  memory write line
- mem_resp  in  1  memory done, one-cycle pulse
- mem_rdata  in  LINE_WIDTH  memory read line, valid with mem_resp

## Operation
- States: IDLE, SERVE_I, SERVE_D, RESP.
- In IDLE, a requester is pending when it asserts i_read, or d_read|d_write.
  - Only one pending: grant it.
  - Both pending: grant the one not equal to last_grant.
  - On grant, latch addr, op (read/write) and d_wdata into registers, update last_grant, and go to SERVE_I or SERVE_D.
- SERVE_x:
  - mem_read or mem_write and mem_addr/mem_wdata are driven from the latched registers only. Requester inputs are ignored after grant.
  - On mem_resp, capture mem_rdata into the line buffer (reads only) and go to RESP.
- RESP:
  - Assert the granted requester's resp for exactly one cycle, with x_rdata = line buffer.
  - Memory request outputs are 0.
  - Next state is always IDLE. The requester drops its request on the same edge, so it is not re-granted.
- d_read and d_write asserted together is a protocol violation. Write takes precedence.
- i_rdata and d_rdata both show the line buffer at all times. Consumers must qualify them with resp.
- Outputs not listed as active in a state are 0.

## Timing
- Reset (async assert, sync release): state=IDLE, last_grant=I, line buffer=0.
  - All outputs 0: i_resp, d_resp, mem_read, mem_write, mem_addr, mem_wdata, i_rdata, d_rdata.
  - With last_grant=I, the first tie after reset goes to dcache.
- Request sampled in IDLE at cycle 0 → mem_read/mem_write high from cycle 1.
- mem_resp high at cycle k → requester resp high at cycle k+1 → IDLE at k+2. Earliest next grant is then at k+3.
- Minimum transaction with 1-cycle memory is 4 cycles (IDLE, SERVE, RESP, IDLE).
- The memory request is deasserted in the cycle after mem_resp and never re-asserted for the same transaction.
- reset_n low mid-transaction: the transaction is abandoned and all outputs go to 0 immediately (asynchronous). The requester must re-issue.
- A request arriving during SERVE_x or RESP for the other requester waits in IDLE. It is never dropped.

## Structure
- Shared package lc3b_types holds:
  - lc3b_word (16-bit)
  - lc3b_line (128-bit)
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, RESP}
  - arb_req_t enum {REQ_I, REQ_D}
- One sub-module: line_reg, a LINE_WIDTH load-enabled register with async active-low clear. It is used for the line buffer and the latched write data.
- Next-state logic and output decode live in the top-level arbiter.

## Test plan
- **icache read alone:** i_read, i_addr=0x1230; memory responds after 3 cycles with 0x…CAFE → mem_addr=0x1230, i_resp one cycle with i_rdata=0x…CAFE, d_resp never asserted.
- **Simultaneous i_read and d_read after reset:** dcache granted first. icache is then granted in the cycle after the dcache transaction returns to IDLE.
- **Back-to-back contention:** both requesters re-request continuously for 6 transactions → grants alternate D, I, D, I, D, I, with no starvation.
- **dcache writeback:** d_write, d_addr=0x4440, d_wdata=0xA5A5…; d_wdata is changed after the grant → mem_write=1 with the original data; d_resp pulses once; mem_read stays 0.
- **Reset mid-transaction:** reset_n low during SERVE_D → all outputs 0 within the same cycle, state IDLE. After release with i_read high, icache is granted normally.
- **Illegal d_read+d_write:** treated as a write → mem_write=1, mem_read=0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types: word/line widths, arbiter state and requester ids,
// plus the round-robin pick used when both caches want the line port.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} arb_req_t;

  // A lone requester always wins; on a tie the one not served last time wins.
  function automatic arb_req_t rr_pick(input logic i_pend, input logic d_pend,
                                       input arb_req_t last);
    arb_req_t pick;
    if (i_pend && d_pend) pick = (last == REQ_I) ? REQ_D : REQ_I;
    else if (d_pend)      pick = REQ_D;
    else                  pick = REQ_I;
    return pick;
  endfunction

endpackage

// File: rtl/line_reg.sv
// Load-enabled cache-line register with asynchronous active-low clear.
module line_reg #(
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [LINE_WIDTH-1:0] i_d,
  output logic [LINE_WIDTH-1:0] o_q
);

  logic [LINE_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single memory line port between icache and dcache, round-robin on ties,
// latching the granted request so the memory side never sees requester changes mid-flight.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  arb_state_t            r_state, w_next_state;
  arb_req_t              r_last_grant, w_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_is_write;
  logic                  w_i_pend, w_d_pend, w_grant_en, w_serving, w_line_load, w_wdata_load;
  logic [LINE_WIDTH-1:0] w_wdata_q, w_line_q;

  assign w_i_pend     = i_read;
  assign w_d_pend     = d_read | d_write;
  assign w_grant_en   = (r_state == IDLE) && (w_i_pend || w_d_pend);
  assign w_grant      = rr_pick(w_i_pend, w_d_pend, r_last_grant);
  assign w_serving    = (r_state == SERVE_I) || (r_state == SERVE_D);
  assign w_line_load  = w_serving && mem_resp && !r_is_write;
  assign w_wdata_load = w_grant_en && (w_grant == REQ_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:             if (w_grant_en) w_next_state = (w_grant == REQ_D) ? SERVE_D : SERVE_I;
      SERVE_I, SERVE_D: if (mem_resp) w_next_state = RESP;
      RESP:             w_next_state = IDLE;
      default:          w_next_state = IDLE;
    endcase
  end

  // r_last_grant doubles as "who is being served" until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= REQ_I;
      r_addr       <= '0;
      r_is_write   <= 1'b0;
    end else if (w_grant_en) begin
      r_last_grant <= w_grant;
      r_addr       <= (w_grant == REQ_D) ? d_addr : i_addr;
      r_is_write   <= (w_grant == REQ_D) && d_write;
    end
  end

  line_reg #(.LINE_WIDTH(LINE_WIDTH)) u_wdata_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_wdata_load),
    .i_d     (d_wdata),
    .o_q     (w_wdata_q)
  );

  line_reg #(.LINE_WIDTH(LINE_WIDTH)) u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_line_load),
    .i_d     (mem_rdata),
    .o_q     (w_line_q)
  );

  always_comb begin
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      SERVE_I, SERVE_D: begin
        mem_read  = !r_is_write;
        mem_write = r_is_write;
        mem_addr  = r_addr;
        if (r_is_write) mem_wdata = w_wdata_q;
      end
      RESP: begin
        i_resp = (r_last_grant == REQ_I);
        d_resp = (r_last_grant == REQ_D);
      end
      default: ;
    endcase
  end

  assign i_rdata = w_line_q;
  assign d_rdata = w_line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: requester and memory agents, a transaction-rule
// reference model checked every cycle, and literal expectations for the directed cases.
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];

  // ---------------- requester agents ----------------
  bit   i_busy = 0, d_busy = 0, i_seen = 0, d_seen = 0, scramble = 0;
  int   issue_pct = 100;
  txn_t drv_t;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      i_busy = 0; d_busy = 0;
      i_read = 0; d_read = 0; d_write = 0;
    end else begin
      if (i_busy && i_seen) i_busy = 0;
      if (d_busy && d_seen) d_busy = 0;
      if (!i_busy) begin
        i_read = 0;
        if (iq.size() > 0 && $urandom_range(99) < issue_pct) begin
          drv_t = iq.pop_front();
          i_read = 1; i_addr = drv_t.addr; i_busy = 1;
        end
      end
      if (!d_busy) begin
        d_read = 0; d_write = 0;
        if (dq.size() > 0 && $urandom_range(99) < issue_pct) begin
          drv_t = dq.pop_front();
          d_read = drv_t.rd; d_write = drv_t.wr; d_addr = drv_t.addr; d_wdata = drv_t.wdata;
          d_busy = 1;
        end
      end else if (scramble) begin
        d_wdata = rnd_line();
        d_addr  = AW'($urandom);
      end
    end
  end

  // ---------------- memory agent ----------------
  int            mem_lat = 1;
  bit            mem_lat_rand = 0, force_rdata = 0, m_active = 0;
  int            m_cnt = 0;
  logic [LW-1:0] forced_line = '0;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      mem_resp = 0; m_active = 0;
    end else if (mem_resp) begin
      mem_resp = 0; mem_rdata = rnd_line();
    end else if (mem_read || mem_write) begin
      if (!m_active) begin
        m_active = 1;
        m_cnt = mem_lat_rand ? int'($urandom_range(4)) : mem_lat;
      end else begin
        m_cnt--;
      end
      if (m_cnt <= 0) begin
        mem_resp = 1; m_active = 0;
        mem_rdata = force_rdata ? forced_line : rnd_line();
      end else begin
        mem_rdata = rnd_line();
      end
    end
  end

  // ---------------- reference model, monitor and per-cycle compare ----------------
  // ph: 0 = no transaction, 1 = waiting on memory, 2 = answering the cache.
  int            ph = 0, m_who = 0, m_last = 0, cyc = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0, m_line = '0;
  bit            ip, dp, prev_req = 0;
  int            i_cnt = 0, d_cnt = 0, mem_rd_cycles = 0;
  int            resp_order[$], resp_cyc[$], req_cyc[$];
  logic [LW-1:0] last_i_rdata = '0, last_d_rdata = '0, last_req_wdata = '0, last_end_wdata = '0;
  logic [AW-1:0] last_req_addr = '0;
  logic          last_req_rd = 0, last_req_wr = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      ph = 0; m_last = 0; m_line = '0;
    end
    chk("cyc_mem_read",  LW'(mem_read),  LW'(ph == 1 && !m_wr));
    chk("cyc_mem_write", LW'(mem_write), LW'(ph == 1 && m_wr));
    chk("cyc_mem_addr",  LW'(mem_addr),  (ph == 1) ? LW'(m_addr) : '0);
    chk("cyc_mem_wdata", mem_wdata,      (ph == 1 && m_wr) ? m_wdata : '0);
    chk("cyc_i_resp",    LW'(i_resp),    LW'(ph == 2 && m_who == 0));
    chk("cyc_d_resp",    LW'(d_resp),    LW'(ph == 2 && m_who == 1));
    chk("cyc_i_rdata",   i_rdata,        m_line);
    chk("cyc_d_rdata",   d_rdata,        m_line);

    i_seen = i_resp;
    d_seen = d_resp;
    if (i_resp) begin i_cnt++; last_i_rdata = i_rdata; resp_order.push_back(0); resp_cyc.push_back(cyc); end
    if (d_resp) begin d_cnt++; last_d_rdata = d_rdata; resp_order.push_back(1); resp_cyc.push_back(cyc); end
    if (mem_read) mem_rd_cycles++;
    if ((mem_read || mem_write) && !prev_req) begin
      req_cyc.push_back(cyc);
      last_req_addr = mem_addr; last_req_rd = mem_read; last_req_wr = mem_write; last_req_wdata = mem_wdata;
    end
    if ((mem_read || mem_write) && mem_resp) last_end_wdata = mem_wdata;
    prev_req = mem_read || mem_write;

    if (reset_n) begin
      case (ph)
        0: begin
          ip = i_read;
          dp = d_read || d_write;
          if (ip || dp) begin
            if (ip && dp) m_who = (m_last == 0) ? 1 : 0;
            else          m_who = dp ? 1 : 0;
            m_last  = m_who;
            m_addr  = (m_who == 1) ? d_addr : i_addr;
            m_wr    = (m_who == 1) && d_write;
            m_wdata = d_wdata;
            ph = 1;
          end
        end
        1: if (mem_resp) begin
          if (!m_wr) m_line = mem_rdata;
          ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_busy || d_busy || ph != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_logs();
    resp_order.delete(); resp_cyc.delete(); req_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk); #2 reset_n = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   i0, d0, n;
  txn_t t;

  initial begin
    // Reset values
    #2;
    chk("rst_i_resp", LW'(i_resp), '0);
    chk("rst_d_resp", LW'(d_resp), '0);
    chk("rst_mem_read", LW'(mem_read), '0);
    chk("rst_mem_write", LW'(mem_write), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    @(posedge clk);

    // icache read alone, 3-cycle memory
    clear_logs(); i0 = i_cnt; d0 = d_cnt;
    mem_lat = 3; force_rdata = 1;
    forced_line = 128'h0123_4567_89AB_CDEF_0011_2233_4455_CAFE;
    iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 16'h1230, wdata: '0});
    wait_done("t1_done", 50);
    force_rdata = 0;
    chk("t1_mem_addr", LW'(last_req_addr), LW'(16'h1230));
    chk("t1_mem_read", LW'(last_req_rd), LW'(1));
    chk("t1_i_resp_count", LW'(i_cnt - i0), LW'(1));
    chk("t1_d_resp_count", LW'(d_cnt - d0), LW'(0));
    chk("t1_i_rdata", last_i_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_CAFE);
    chk("t1_i_rdata_lo", LW'(last_i_rdata[15:0]), LW'(16'hCAFE));

    // Simultaneous reads right after reset: dcache first, icache right after
    apply_reset();
    clear_logs(); mem_lat = 1;
    iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 16'h0100, wdata: '0});
    dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 16'h0200, wdata: '0});
    wait_done("t2_done", 50);
    chk("t2_resp_count", LW'(resp_order.size()), LW'(2));
    if (resp_order.size() == 2 && req_cyc.size() == 2) begin
      chk("t2_first_is_d", LW'(resp_order[0]), LW'(1));
      chk("t2_second_is_i", LW'(resp_order[1]), LW'(0));
      chk("t2_i_grant_gap", LW'(req_cyc[1] - resp_cyc[0]), LW'(2));
    end

    // Back-to-back contention, 3 transactions per cache
    clear_logs(); mem_lat_rand = 1;
    for (int k = 0; k < 3; k++) begin
      iq.push_back('{rd: 1'b1, wr: 1'b0, addr: AW'($urandom), wdata: '0});
      dq.push_back('{rd: 1'b1, wr: 1'b0, addr: AW'($urandom), wdata: '0});
    end
    wait_done("t3_done", 200);
    chk("t3_resp_count", LW'(resp_order.size()), LW'(6));
    for (int k = 0; k < resp_order.size() && k < 6; k++)
      chk($sformatf("t3_order_%0d", k), LW'(resp_order[k]), LW'((k % 2 == 0) ? 1 : 0));
    mem_lat_rand = 0;

    // dcache writeback with d_wdata/d_addr changing after the grant
    clear_logs(); d0 = d_cnt; mem_rd_cycles = 0; mem_lat = 2; scramble = 1;
    dq.push_back('{rd: 1'b0, wr: 1'b1, addr: 16'h4440, wdata: {8{16'hA5A5}}});
    wait_done("t4_done", 50);
    scramble = 0;
    chk("t4_mem_write", LW'(last_req_wr), LW'(1));
    chk("t4_mem_addr", LW'(last_req_addr), LW'(16'h4440));
    chk("t4_wdata_start", last_req_wdata, {8{16'hA5A5}});
    chk("t4_wdata_end", last_end_wdata, {8{16'hA5A5}});
    chk("t4_mem_read_cycles", LW'(mem_rd_cycles), LW'(0));
    chk("t4_d_resp_count", LW'(d_cnt - d0), LW'(1));

    // Reset in the middle of SERVE_D
    mem_lat = 20;
    dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 16'h0777, wdata: '0});
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_read && n < 30);
    chk("t5_serve_reached", LW'(mem_read), LW'(1));
    #2 reset_n = 0;
    #1;
    chk("t5_i_resp", LW'(i_resp), '0);
    chk("t5_d_resp", LW'(d_resp), '0);
    chk("t5_mem_read", LW'(mem_read), '0);
    chk("t5_mem_write", LW'(mem_write), '0);
    chk("t5_mem_addr", LW'(mem_addr), '0);
    chk("t5_i_rdata", i_rdata, '0);
    chk("t5_d_rdata", d_rdata, '0);
    dq.delete();
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    mem_lat = 1; i0 = i_cnt;
    iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 16'h0BEE, wdata: '0});
    wait_done("t5_done", 50);
    chk("t5_i_resp_count", LW'(i_cnt - i0), LW'(1));
    chk("t5_mem_addr_after", LW'(last_req_addr), LW'(16'h0BEE));

    // Illegal d_read + d_write behaves as a write
    d0 = d_cnt;
    dq.push_back('{rd: 1'b1, wr: 1'b1, addr: 16'h2220, wdata: rnd_line()});
    wait_done("t6_done", 50);
    chk("t6_mem_write", LW'(last_req_wr), LW'(1));
    chk("t6_mem_read", LW'(last_req_rd), LW'(0));
    chk("t6_d_resp_count", LW'(d_cnt - d0), LW'(1));

    // Randomized traffic: nothing dropped, nobody starved
    i0 = i_cnt; d0 = d_cnt; issue_pct = 60; mem_lat_rand = 1;
    for (int k = 0; k < 40; k++) begin
      iq.push_back('{rd: 1'b1, wr: 1'b0, addr: AW'($urandom), wdata: '0});
      n = int'($urandom_range(9));
      t.rd = (n < 5) || (n == 9);
      t.wr = (n >= 5);
      t.addr = AW'($urandom);
      t.wdata = rnd_line();
      dq.push_back(t);
    end
    wait_done("t7_done", 5000);
    chk("t7_i_resp_count", LW'(i_cnt - i0), LW'(40));
    chk("t7_d_resp_count", LW'(d_cnt - d0), LW'(40));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
